alu_bus_sequencer: RTL and testbench
====================================

// Module: alu_bus_sequencer
// PURPOSE
//  Control sequencer sitting directly upstream of the ALU on the shared 262-bit
//  matrix bus. Accepts one matrix instruction (opcode, two source regs, dest reg),
//  then steps the register file and ALU strobes (enable/in1/in2/compute/out/over)
//  so that exactly one agent drives the bus per cycle, and reports completion.
//  It never drives bus data itself; it only sequences who drives it.
// PARAMETERS
//  ADDR_W    3    register-file address width (8 matrix registers)
//  TIMEOUT   64   max cycles in COMPUTE waiting for alu_done before abort
//  OVER_BIT  6    opcode bit that requests a second write-back of the over result
// PORTS
//  clock          in   1       system clock, all state on rising edge
//  reset          in   1       synchronous, active-high
//  start          in   1       instruction valid; sampled only in IDLE
//  opcode         in   7       ALU operation, captured on accepted start
//  src1, src2     in   ADDR_W  source register addresses, captured on start
//  dest           in   ADDR_W  destination register address, captured on start
//  busy           out  1       high from cycle after accept until return to IDLE
//  instr_done     out  1       1-cycle pulse: instruction completed and written back
//  error          out  1       1-cycle pulse: compute timed out, no write-back
//  rf_rd_en       out  1       register file drives rf_rd_addr onto bus
//  rf_rd_addr     out  ADDR_W  register file read address
//  rf_wr_en       out  1       register file latches bus into rf_wr_addr
//  rf_wr_addr     out  ADDR_W  register file write address
//  alu_enable     out  1       ALU bus enable
//  alu_in1/in2    out  1       ALU latches bus as operand 1 / 2
//  alu_compute    out  1       ALU computes (held until done)
//  alu_out        out  1       ALU drives primary result onto bus
//  alu_over       out  1       ALU drives over/secondary result onto bus
//  alu_operation  out  7       registered opcode to ALU
//  alu_done       in   1       ALU result ready
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, captured regs 0, timeout counter 0.
//    Reset in any state aborts immediately; no instr_done/error pulse.
//  - FSM: IDLE -> LOAD1 -> LOAD2 -> COMPUTE -> WB -> [WB_OVER] -> ACK -> IDLE;
//    COMPUTE -> ABORT -> IDLE on timeout.
//  - IDLE: start=1 captures opcode/src1/src2/dest, next LOAD1. start ignored elsewhere.
//  - LOAD1 (1 cyc): rf_rd_en=1, rf_rd_addr=src1, alu_enable=1, alu_in1=1.
//  - LOAD2 (1 cyc): rf_rd_en=1, rf_rd_addr=src2, alu_enable=1, alu_in2=1.
//  - COMPUTE: alu_enable=1, alu_compute=1; counter increments each cycle.
//    alu_done=1 at edge -> WB. Counter reaching TIMEOUT-1 with no done -> ABORT.
//    done and timeout on same edge: done wins.
//  - WB (1 cyc): alu_enable=1, alu_out=1, rf_wr_en=1, rf_wr_addr=dest.
//    Next WB_OVER if opcode[OVER_BIT]=1, else ACK.
//  - WB_OVER (1 cyc): alu_enable=1, alu_over=1, rf_wr_en=1, rf_wr_addr=dest+1
//    (wraps modulo 2^ADDR_W: dest=7 -> addr 0).
//  - ACK: instr_done=1 for one cycle; ABORT: error=1 for one cycle; both -> IDLE.
//  - alu_operation = captured opcode, stable from LOAD1 through ACK.
//  - Invariant: at most one of {rf_rd_en, alu_out, alu_over} high in any cycle;
//    alu_in1/in2/compute/out/over mutually exclusive. All outputs registered.
//  - busy=1 in every state except IDLE. src1==src2 or dest==src legal, no special case.
//  - Latency: start accepted at edge N -> LOAD1 N+1, LOAD2 N+2, COMPUTE N+3;
//    done seen at edge M -> WB M+1, instr_done at M+2 (M+3 with OVER_BIT).
// TESTING
//  1. reset 2 cyc, start opcode=7'h04 src1=1 src2=2 dest=3, done 3 cyc into COMPUTE
//     -> in1 w/ rd_addr=1, in2 w/ rd_addr=2, wr_en addr=3 w/ alu_out, one instr_done.
//  2. opcode=7'h44 dest=7 -> WB addr 7 then WB_OVER alu_over=1 addr 0, then instr_done.
//  3. alu_done never asserted -> after 64 COMPUTE cycles error pulse, no rf_wr_en, IDLE.
//  4. start held high throughout + second start mid-COMPUTE -> exactly one instruction
//     per IDLE visit; captured src/dest unchanged until ACK.
//  5. reset asserted during COMPUTE -> next cycle all outputs 0, no pulses, IDLE.
//  6. Every cycle of all tests: check bus-driver exclusivity invariant; done and
//     timeout on the same edge -> WB, not ABORT.

Source files
------------

// File: rtl/alu_bus_sequencer.sv
// Sequences register-file and ALU strobes so exactly one agent drives the matrix bus per cycle.
// Strobes are registered from next state: LOAD1 visible the cycle after start is accepted; start is ignored while busy.
module alu_bus_sequencer #(
  parameter int ADDR_W   = 3,
  parameter int TIMEOUT  = 64,
  parameter int OVER_BIT = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [6:0]        opcode,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic [ADDR_W-1:0] dest,
  output logic              busy,
  output logic              instr_done,
  output logic              error,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic              alu_enable,
  output logic              alu_in1,
  output logic              alu_in2,
  output logic              alu_compute,
  output logic              alu_out,
  output logic              alu_over,
  output logic [6:0]        alu_operation,
  input  logic              alu_done
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD1   = 3'd1;
  localparam logic [2:0] S_LOAD2   = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
  localparam logic [2:0] S_WB_OVER = 3'd5;
  localparam logic [2:0] S_ACK     = 3'd6;
  localparam logic [2:0] S_ABORT   = 3'd7;

  logic [2:0]        state;
  logic [2:0]        nxt;
  logic [CNT_W-1:0]  cnt;
  logic [6:0]        op_q;
  logic [ADDR_W-1:0] src2_q;
  logic [ADDR_W-1:0] dest_q;

  assign alu_operation = op_q;

  // alu_done is tested before the timeout so a simultaneous done still writes back.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (start) nxt = S_LOAD1;
      S_LOAD1:   nxt = S_LOAD2;
      S_LOAD2:   nxt = S_COMPUTE;
      S_COMPUTE: begin
        if (alu_done)                              nxt = S_WB;
        else if (cnt == CNT_W'(TIMEOUT - 1))       nxt = S_ABORT;
      end
      S_WB:      nxt = op_q[OVER_BIT] ? S_WB_OVER : S_ACK;
      S_WB_OVER: nxt = S_ACK;
      S_ACK:     nxt = S_IDLE;
      S_ABORT:   nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_q        <= '0;
      src2_q      <= '0;
      dest_q      <= '0;
      busy        <= 1'b0;
      instr_done  <= 1'b0;
      error       <= 1'b0;
      rf_rd_en    <= 1'b0;
      rf_rd_addr  <= '0;
      rf_wr_en    <= 1'b0;
      rf_wr_addr  <= '0;
      alu_enable  <= 1'b0;
      alu_in1     <= 1'b0;
      alu_in2     <= 1'b0;
      alu_compute <= 1'b0;
      alu_out     <= 1'b0;
      alu_over    <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= (state == S_COMPUTE) ? cnt + CNT_W'(1) : '0;
      if (state == S_IDLE && start) begin
        op_q   <= opcode;
        src2_q <= src2;
        dest_q <= dest;
      end
      busy        <= (nxt != S_IDLE);
      instr_done  <= (nxt == S_ACK);
      error       <= (nxt == S_ABORT);
      rf_rd_en    <= (nxt == S_LOAD1) || (nxt == S_LOAD2);
      // LOAD1 is only reached from an accepted start, so src1 is taken straight from the port.
      rf_rd_addr  <= (nxt == S_LOAD1) ? src1 :
                     (nxt == S_LOAD2) ? src2_q : '0;
      rf_wr_en    <= (nxt == S_WB) || (nxt == S_WB_OVER);
      rf_wr_addr  <= (nxt == S_WB)      ? dest_q :
                     (nxt == S_WB_OVER) ? dest_q + ADDR_W'(1) : '0;
      alu_enable  <= (nxt == S_LOAD1) || (nxt == S_LOAD2) || (nxt == S_COMPUTE) ||
                     (nxt == S_WB) || (nxt == S_WB_OVER);
      alu_in1     <= (nxt == S_LOAD1);
      alu_in2     <= (nxt == S_LOAD2);
      alu_compute <= (nxt == S_COMPUTE);
      alu_out     <= (nxt == S_WB);
      alu_over    <= (nxt == S_WB_OVER);
    end
  end

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// Bench for alu_bus_sequencer: per-instruction expected trace model, per-cycle compare, directed literal checks.
module tb_alu_bus_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] src1 = '0, src2 = '0, dest = '0;
  logic       busy, instr_done, error, rf_rd_en, rf_wr_en;
  logic [2:0] rf_rd_addr, rf_wr_addr;
  logic       alu_enable, alu_in1, alu_in2, alu_compute, alu_out, alu_over;
  logic [6:0] alu_operation;
  logic       alu_done = 1'b0;

  always #5 clock = ~clock;

  alu_bus_sequencer #(.ADDR_W(3), .TIMEOUT(64), .OVER_BIT(6)) dut (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode),
    .src1(src1), .src2(src2), .dest(dest),
    .busy(busy), .instr_done(instr_done), .error(error),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
    .alu_enable(alu_enable), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_compute(alu_compute), .alu_out(alu_out), .alu_over(alu_over),
    .alu_operation(alu_operation), .alu_done(alu_done)
  );

  typedef struct packed {
    logic       busy, done, err, rd_en;
    logic [2:0] rd_addr;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic       en, in1, in2, comp, out, over;
    logic       op_chk;
    logic [6:0] op;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   plan_k = 0;      // compute cycles before alu_done; 0 means never
  int   done_edge = 0;
  bit   model_on = 0;
  exp_t cur = '0;
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Whole instruction trace from the operation rules: two loads, compute, write-back(s), then ack or abort.
  task automatic build(input logic [6:0] op, input logic [2:0] s1, input logic [2:0] s2,
                       input logic [2:0] d, input int k);
    exp_t b, r;
    logic [2:0] d1;
    int n;
    b = '0; b.busy = 1; b.op_chk = 1; b.op = op; b.en = 1;
    r = b; r.rd_en = 1; r.rd_addr = s1; r.in1 = 1; q.push_back(r);
    r = b; r.rd_en = 1; r.rd_addr = s2; r.in2 = 1; q.push_back(r);
    n = (k == 0) ? 64 : k;
    for (int i = 0; i < n; i++) begin
      r = b; r.comp = 1; q.push_back(r);
    end
    if (k != 0) begin
      r = b; r.wr_en = 1; r.wr_addr = d; r.out = 1; q.push_back(r);
      if (op[6]) begin
        d1 = d + 3'd1;
        r = b; r.wr_en = 1; r.wr_addr = d1; r.over = 1; q.push_back(r);
      end
      r = '0; r.busy = 1; r.done = 1; r.op_chk = 1; r.op = op; q.push_back(r);
    end else begin
      r = '0; r.busy = 1; r.err = 1; q.push_back(r);
    end
  endtask

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      q.delete();
      cur = '0; cur.op_chk = 1;
      done_edge = 0;
      model_on = 1;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (!cur.busy && start) begin
      build(opcode, src1, src2, dest, plan_k);
      done_edge = (plan_k == 0) ? 0 : cyc + 2 + plan_k;
      cur = q.pop_front();
    end else begin
      cur = '0;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      alu_done = (done_edge != 0) && (cyc + 1 == done_edge);
    end
  end

  always @(negedge clock) begin
    if (model_on) begin
      check("outputs",
            {15'd0, busy, instr_done, error, rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr,
             alu_enable, alu_in1, alu_in2, alu_compute, alu_out, alu_over},
            {15'd0, cur.busy, cur.done, cur.err, cur.rd_en, cur.rd_addr, cur.wr_en, cur.wr_addr,
             cur.en, cur.in1, cur.in2, cur.comp, cur.out, cur.over});
      if (cur.op_chk) check("alu_operation", {25'd0, alu_operation}, {25'd0, cur.op});
      check("bus_driver_excl", {31'd0, $onehot0({rf_rd_en, alu_out, alu_over})}, 32'd1);
      check("alu_strobe_excl", {31'd0, $onehot0({alu_in1, alu_in2, alu_compute, alu_out, alu_over})}, 32'd1);
    end
  end

  task automatic issue(input logic [6:0] op, input logic [2:0] s1, input logic [2:0] s2,
                       input logic [2:0] d, input int k, output int e);
    @(negedge clock);
    opcode = op; src1 = s1; src2 = s2; dest = d; plan_k = k; start = 1'b1;
    @(negedge clock);
    e = cyc;
    start = 1'b0;
  endtask

  task automatic to_edge(input int e, input int n);
    while (cyc < e + n) @(negedge clock);
  endtask

  initial begin
    int e;
    repeat (2) @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_op", {25'd0, alu_operation}, 32'd0);
    reset = 1'b0;

    // Basic instruction, done after 3 compute cycles.
    issue(7'h04, 3'd1, 3'd2, 3'd3, 3, e);
    to_edge(e, 0); check("t1_in1", {31'd0, alu_in1}, 32'd1); check("t1_rd1", {29'd0, rf_rd_addr}, 32'd1);
    to_edge(e, 1); check("t1_in2", {31'd0, alu_in2}, 32'd1); check("t1_rd2", {29'd0, rf_rd_addr}, 32'd2);
    to_edge(e, 4); check("t1_comp", {31'd0, alu_compute}, 32'd1); check("t1_nowr", {31'd0, rf_wr_en}, 32'd0);
    to_edge(e, 5); check("t1_wb", {30'd0, rf_wr_en, alu_out}, 32'd3); check("t1_wa", {29'd0, rf_wr_addr}, 32'd3);
    to_edge(e, 6); check("t1_done", {31'd0, instr_done}, 32'd1);
    to_edge(e, 7); check("t1_idle", {30'd0, instr_done, busy}, 32'd0);

    // Over write-back with dest wrap 7 -> 0.
    issue(7'h44, 3'd0, 3'd5, 3'd7, 1, e);
    to_edge(e, 3); check("t2_wb", {29'd0, rf_wr_addr}, 32'd7); check("t2_out", {31'd0, alu_out}, 32'd1);
    to_edge(e, 4); check("t2_over", {30'd0, alu_over, rf_wr_en}, 32'd3); check("t2_wrap", {29'd0, rf_wr_addr}, 32'd0);
    to_edge(e, 5); check("t2_done", {31'd0, instr_done}, 32'd1); check("t2_op", {25'd0, alu_operation}, 32'h44);

    // Timeout, with src1 == src2 == dest.
    issue(7'h10, 3'd3, 3'd3, 3'd3, 0, e);
    to_edge(e, 65); check("t3_last_comp", {30'd0, alu_compute, error}, 32'd2);
    to_edge(e, 66); check("t3_err", {29'd0, error, rf_wr_en, alu_compute}, 32'd4);
    to_edge(e, 67); check("t3_idle", {30'd0, busy, error}, 32'd0);

    // alu_done on the timeout edge must still write back.
    issue(7'h2a, 3'd6, 3'd1, 3'd5, 64, e);
    to_edge(e, 66); check("t6_wb", {29'd0, alu_out, rf_wr_en, error}, 32'd6); check("t6_wa", {29'd0, rf_wr_addr}, 32'd5);
    to_edge(e, 67); check("t6_done", {31'd0, instr_done}, 32'd1);
    repeat (3) @(negedge clock);

    // start held high; inputs change mid-compute; second instruction only after an IDLE cycle.
    @(negedge clock);
    opcode = 7'h41; src1 = 3'd4; src2 = 3'd5; dest = 3'd6; plan_k = 5; start = 1'b1;
    @(negedge clock);
    e = cyc;
    to_edge(e, 3);
    opcode = 7'h03; src1 = 3'd7; src2 = 3'd0; dest = 3'd2; plan_k = 2;
    to_edge(e, 7); check("t4_wa", {29'd0, rf_wr_addr}, 32'd6);
    to_edge(e, 8); check("t4_over", {31'd0, alu_over}, 32'd1); check("t4_wa1", {29'd0, rf_wr_addr}, 32'd7);
    to_edge(e, 9); check("t4_done", {31'd0, instr_done}, 32'd1); check("t4_op", {25'd0, alu_operation}, 32'h41);
    to_edge(e, 10); check("t4_idle", {31'd0, busy}, 32'd0);
    to_edge(e, 11); check("t4_b_in1", {31'd0, alu_in1}, 32'd1); check("t4_b_rd", {29'd0, rf_rd_addr}, 32'd7);
    check("t4_b_op", {25'd0, alu_operation}, 32'h03);
    start = 1'b0;
    repeat (12) @(negedge clock);

    // Reset mid-compute: everything clears, no pulses afterwards.
    issue(7'h04, 3'd1, 3'd2, 3'd3, 0, e);
    to_edge(e, 4);
    reset = 1'b1;
    @(negedge clock);
    check("t5_clr", {27'd0, busy, alu_enable, alu_compute, instr_done, error}, 32'd0);
    check("t5_op", {25'd0, alu_operation}, 32'd0);
    reset = 1'b0;
    repeat (70) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
